// File: rtl/csa_result_buffer.sv
// Result buffer behind the 8-bit carry-skip adder: derives N/V/Z/C flags,
// queues {flags, sum} in a first-word-fall-through FIFO and counts overflows.
module csa_result_buffer #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             a_in,
  input  logic [W-1:0]             b_in,
  input  logic [W-1:0]             sum_in,
  input  logic                     cout_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_sum,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            ovf_cnt,
  input  logic                     clr_ovf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned EW   = W + 4;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            flag_n, flag_v, flag_z, flag_c;
  logic            push, pop;
  logic [EW-1:0]   head;

  // Only the operand sign bits matter for overflow detection.
  logic            unused_operand_bits;
  assign unused_operand_bits = ^{a_in[W-2:0], b_in[W-2:0]};

  // Flag derivation from the incoming result.
  always_comb begin
    flag_c = cout_in;
    flag_z = (sum_in == '0);
    flag_n = sum_in[W-1];
    flag_v = (a_in[W-1] == b_in[W-1]) && (sum_in[W-1] != a_in[W-1]);
  end

  assign in_ready  = (count_q != CNTW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer, occupancy and overflow-counter next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_cnt_d = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);

    if (clr_ovf)
      ovf_cnt_d = '0;
    else if (push && flag_v && (ovf_cnt_q != {CW{1'b1}}))
      ovf_cnt_d = ovf_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage is not reset; stale entries are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {flag_n, flag_v, flag_z, flag_c, sum_in};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_sum   = '0;
    out_flags = '0;
    if (out_valid) begin
      out_sum   = head[W-1:0];
      out_flags = head[EW-1:W];
    end
  end

  assign count   = count_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_csa_result_buffer.sv
// Directed bench for csa_result_buffer: flags, FIFO ordering, full/empty
// handling, overflow counter saturation/clear and mid-operation reset.
module tb_csa_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in, b_in, sum_in;
  logic       cout_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic [7:0] ovf_cnt;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  csa_result_buffer #(.W(8), .DEPTH(4), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .count     (count),
    .ovf_cnt   (ovf_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] s, input logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    sum_in   = s;
    cout_in  = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(); cycle();
    rst_n = 1'b1;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs got valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 8'h00 || out_flags !== 4'h0 || ovf_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_outs got sum=%h flags=%b ovf=%0d exp 0", out_sum, out_flags, ovf_cnt);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'h0F, 8'h01, 8'h10, 1'b0);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h10 || out_flags !== 4'b0000 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_push got v=%b sum=%h flags=%b cnt=%0d exp 1/10/0000/1",
               out_valid, out_sum, out_flags, count);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'h00 || count !== 3'd0) begin
      errors++; $display("FAIL single_pop got v=%b sum=%h cnt=%0d exp 0/00/0", out_valid, out_sum, count);
    end
  endtask

  task automatic test_flags();
    logic [7:0] va [3] = '{8'h7F, 8'hFF, 8'h80};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h80};
    logic [7:0] vs [3] = '{8'h80, 8'h00, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] ef [3] = '{4'b1100, 4'b0011, 4'b0111};
    logic [7:0] eo [3] = '{8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      drive(1'b1, va[i], vb[i], vs[i], vc[i]);
      cycle();
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (out_flags !== ef[i] || out_sum !== vs[i] || ovf_cnt !== eo[i]) begin
        errors++;
        $display("FAIL flags_%0d got flags=%b sum=%h ovf=%0d exp %b/%h/%0d",
                 i, out_flags, out_sum, ovf_cnt, ef[i], vs[i], eo[i]);
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'h00, 8'(i), 8'(i), 1'b0);
      cycle();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got cnt=%0d ready=%b exp 4/0", count, in_ready);
    end
    drive(1'b1, 8'h00, 8'h05, 8'h05, 1'b0);
    cycle();
    checks++;
    if (count !== 3'd4 || out_sum !== 8'h01) begin
      errors++; $display("FAIL fill_reject got cnt=%0d head=%h exp 4/01", count, out_sum);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'(i)) begin
        errors++; $display("FAIL drain_%0d got v=%b sum=%h exp 1/%h", i, out_valid, out_sum, 8'(i));
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL drain_empty got v=%b cnt=%0d exp 0/0", out_valid, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h00, 8'(i), 8'(i), 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      drive(1'b1, 8'h00, 8'(i), 8'(i), 1'b0);
      checks++;
      if (count !== 3'd2 || out_sum !== 8'(i - 2)) begin
        errors++; $display("FAIL b2b_%0d got cnt=%0d sum=%h exp 2/%h", i, count, out_sum, 8'(i - 2));
      end
      cycle();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 8; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'(i)) begin
        errors++; $display("FAIL b2b_tail_%0d got v=%b sum=%h exp 1/%h", i, out_valid, out_sum, 8'(i));
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got v=%b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_ovf_sat();
    out_ready = 1'b1;
    drive(1'b1, 8'h40, 8'h40, 8'h80, 1'b0);
    for (int i = 0; i < 300; i++) cycle();
    checks++;
    if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_sat got %0d exp 255", ovf_cnt); end
    cycle();
    checks++;
    if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_hold got %0d exp 255", ovf_cnt); end
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr got %0d exp 0", ovf_cnt); end
    cycle();
    checks++;
    if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_after_clr got %0d exp 1", ovf_cnt); end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(); cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h40, 8'h40, 8'h80, 1'b0);
    cycle();
    drive(1'b1, 8'h00, 8'h21, 8'h21, 1'b0);
    cycle(); cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checks++;
    if (count !== 3'd3 || ovf_cnt !== 8'd2) begin
      errors++; $display("FAIL pre_reset got cnt=%0d ovf=%0d exp 3/2", count, ovf_cnt);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_cnt !== 8'd0 || out_sum !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d v=%b ready=%b ovf=%0d sum=%h exp 0/0/1/0/00",
               count, out_valid, in_ready, ovf_cnt, out_sum);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_fill();
    test_back_to_back();
    test_ovf_sat();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_result_buffer.md
Name: csa_result_buffer

Overview:
- Downstream stage of the 8-bit carry-skip adder. Captures each adder result together with the operands that produced it.
- Derives the status flags C (carry), Z (zero), V (signed overflow) and N (negative).
- Queues {flags, sum} in a small FIFO with valid/ready handshakes on both sides, so consumers can stall without losing results.
- Keeps a saturating count of signed-overflow events for debug.

Parameters:
- W, 8, datapath width; matches the adder's sum width.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CW, 8, width of the overflow event counter.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, upstream has a result on sum_in/cout_in/a_in/b_in.
- in_ready, output, 1, buffer can accept an entry this cycle.
- a_in, input, W, operand A that was applied to the adder.
- b_in, input, W, operand B that was applied to the adder.
- sum_in, input, W, adder sum output.
- cout_in, input, 1, adder carry-out.
- out_valid, output, 1, head entry is available.
- out_ready, input, 1, consumer takes the head entry.
- out_sum, output, W, head entry sum.
- out_flags, output, 4, head entry flags {N,V,Z,C} (bit3..bit0).
- count, output, clog2(DEPTH)+1, number of occupied entries.
- ovf_cnt, output, CW, saturating count of accepted entries with V=1.
- clr_ovf, input, 1, synchronous clear of ovf_cnt.

Behaviour:
- Flag derivation is combinational on the inputs and stored at push time.
  - C = cout_in.
  - Z = (sum_in == 0).
  - N = sum_in[W-1].
  - V = (a_in[W-1] == b_in[W-1]) && (sum_in[W-1] != a_in[W-1]).
- Push: occurs on a rising edge with in_valid && in_ready.
- Pop: occurs on a rising edge with out_valid && out_ready.
- in_ready = (count != DEPTH), derived from registered state only. It never depends combinationally on out_ready: no pass-through when full.
- out_valid = (count != 0).
- Head output is first-word fall-through:
  - out_sum/out_flags = head entry while out_valid = 1.
  - out_sum/out_flags are forced to 0 when empty.
- Latency: a push at edge k makes out_valid = 1 after edge k (visible in cycle k+1). Minimum latency is 1 cycle.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update:
  - push only: count +1.
  - pop only: count -1.
  - push and pop in the same cycle (possible only when 0 < count < DEPTH): count unchanged, both pointers advance.
- Empty: out_ready is ignored, with no pointer or count change.
- Full: in_valid is ignored (in_ready = 0). The upstream holds its data; nothing is dropped inside this block.
- ovf_cnt:
  - Increments by 1 on each push whose V = 1.
  - Saturates at 2^CW-1; no wrap.
  - clr_ovf has priority over an increment in the same cycle; the result is 0.
- Reset (rst_n = 0 at an edge), including mid-operation:
  - wr_ptr, rd_ptr, count and ovf_cnt go to 0.
  - The FIFO is empty, out_valid = 0, in_ready = 1 (count = 0, i.e. not full), out_sum = 0, out_flags = 0.
  - In-flight entries are discarded.
  - Storage array contents are not reset; they are unobservable because outputs are masked when empty.
- No combinational path from in_* to out_*.

Test Plan:
- Reset then single push: a=0x0F, b=0x01, sum=0x10, cout=0.
  - Next cycle: out_valid=1, out_sum=0x10, out_flags=0000, count=1.
  - Pop: out_valid=0, out_sum=0.
- Flag coverage:
  - push a=0x7F, b=0x01, sum=0x80, cout=0 -> flags 1100 (N,V), ovf_cnt=1.
  - push a=0xFF, b=0x01, sum=0x00, cout=1 -> flags 0011 (Z,C).
  - push a=0x80, b=0x80, sum=0x00, cout=1 -> flags 0111, ovf_cnt=2.
- Fill with out_ready=0: push 4 entries with sum 0x01..0x04.
  - count=4, in_ready=0.
  - A 5th in_valid is not accepted.
  - Then drain with out_ready=1: outputs 0x01,0x02,0x03,0x04 in order, then out_valid=0.
- Simultaneous push/pop at count=2: count stays 2. Order is preserved across pointer wrap; run 10 continuous entries, 0x00..0x09 out in order.
- ovf_cnt behaviour:
  - 300 pushes of overflowing operands (a=0x40, b=0x40, sum=0x80) -> ovf_cnt=255, held at 255.
  - clr_ovf pulsed together with an overflowing push -> ovf_cnt=0.
- Reset mid-operation with count=3 -> next cycle count=0, out_valid=0, in_ready=1, ovf_cnt=0.
